// File: rtl/ninjin_stream_unpack.sv
// ninjin_stream_unpack: splits 32-bit host stream words into two 16-bit
// half-words and writes them sequentially into core image memory, starting
// at a base address latched on req and stopping after len half-words.
// Optional build macro: NINJIN_SWAP_EN (write upper half first).
//
// state  | meaning
// S_IDLE | waiting for req; all outputs low
// S_RECV | s_ready high, waiting for a host word
// S_LO   | writing first half of buffered word
// S_HI   | writing second half; may accept the next word in the same cycle
// S_DONE | one-cycle ack, then back to idle
module ninjin_stream_unpack #(
   parameter int PORT     = 32,
   parameter int DWIDTH   = 16,
   parameter int MEMSIZE  = 12,
   parameter int LENWIDTH = 12
) (
   input  logic                clk,
   input  logic                xrst,
   input  logic                req,
   input  logic [MEMSIZE-1:0]  base_addr,
   input  logic [LENWIDTH-1:0] len,
   input  logic                s_valid,
   input  logic [PORT-1:0]     s_data,
   output logic                s_ready,
   output logic                mem_we,
   output logic [MEMSIZE-1:0]  mem_addr,
   output logic [DWIDTH-1:0]   mem_wdata,
   output logic                busy,
   output logic                ack
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RECV,
      S_LO,
      S_HI,
      S_DONE
   } state_t;

   state_t              state, state_nx;
   logic [MEMSIZE-1:0]  ptr;
   logic [LENWIDTH-1:0] cnt;
   logic [LENWIDTH-1:0] cnt_inc;
   logic [LENWIDTH-1:0] len_r;
   logic [PORT-1:0]     buf_q;
   logic [DWIDTH-1:0]   first_half;
   logic [DWIDTH-1:0]   second_half;
   logic                last;

`ifdef NINJIN_SWAP_EN
   assign first_half  = buf_q[PORT-1:DWIDTH];
   assign second_half = buf_q[DWIDTH-1:0];
`else
   assign first_half  = buf_q[DWIDTH-1:0];
   assign second_half = buf_q[PORT-1:DWIDTH];
`endif

   assign cnt_inc = cnt + 1'b1;
   assign last    = (cnt_inc == len_r);

   // State register
   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) state <= S_IDLE;
      else       state <= state_nx;
   end

   // Next-state and Moore output decode; s_ready depends on registered state only
   always_comb begin
      state_nx  = state;
      s_ready   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      ack       = 1'b0;
      busy      = (state != S_IDLE);
      case (state)
         S_IDLE: begin
            if (req) state_nx = (len == '0) ? S_DONE : S_RECV;
         end
         S_RECV: begin
            s_ready = 1'b1;
            if (s_valid) state_nx = S_LO;
         end
         S_LO: begin
            mem_we    = 1'b1;
            mem_addr  = ptr;
            mem_wdata = first_half;
            state_nx  = last ? S_DONE : S_HI;
         end
         S_HI: begin
            mem_we    = 1'b1;
            mem_addr  = ptr;
            mem_wdata = second_half;
            if (last) begin
               state_nx = S_DONE;
            end else begin
               s_ready  = 1'b1;
               state_nx = s_valid ? S_LO : S_RECV;
            end
         end
         S_DONE: begin
            ack      = 1'b1;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Run bookkeeping: latch run on req, advance pointer/count on each write
   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         ptr   <= '0;
         cnt   <= '0;
         len_r <= '0;
      end else if (state == S_IDLE) begin
         if (req) begin
            ptr   <= base_addr;
            len_r <= len;
            cnt   <= '0;
         end
      end else if (mem_we) begin
         ptr <= ptr + 1'b1;
         cnt <= cnt_inc;
      end
   end

   // Word buffer, loaded only on a handshake
   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst)                  buf_q <= '0;
      else if (s_valid && s_ready) buf_q <= s_data;
   end

endmodule

// File: tb/tb_ninjin_stream_unpack.sv
// Directed bench for ninjin_stream_unpack. Inputs change 1 ns after the
// rising edge; outputs are sampled at that same point, where they reflect
// the state entered at that edge.
module tb_ninjin_stream_unpack;

   logic        clk = 1'b0;
   logic        xrst;
   logic        req;
   logic [11:0] base_addr;
   logic [11:0] len;
   logic        s_valid;
   logic [31:0] s_data;
   logic        s_ready;
   logic        mem_we;
   logic [11:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        busy;
   logic        ack;

   int checks   = 0;
   int failures = 0;

   ninjin_stream_unpack dut (
      .clk       (clk),
      .xrst      (xrst),
      .req       (req),
      .base_addr (base_addr),
      .len       (len),
      .s_valid   (s_valid),
      .s_data    (s_data),
      .s_ready   (s_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .busy      (busy),
      .ack       (ack)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] fh(input logic [31:0] w);
`ifdef NINJIN_SWAP_EN
      return w[31:16];
`else
      return w[15:0];
`endif
   endfunction

   function automatic logic [15:0] sh(input logic [31:0] w);
`ifdef NINJIN_SWAP_EN
      return w[15:0];
`else
      return w[31:16];
`endif
   endfunction

   task automatic check_wr(input string tag, input logic [11:0] a, input logic [15:0] d);
      check({tag, "_we"},   {31'd0, mem_we}, 32'd1);
      check({tag, "_addr"}, {20'd0, mem_addr}, {20'd0, a});
      check({tag, "_data"}, {16'd0, mem_wdata}, {16'd0, d});
   endtask

   function automatic logic [31:0] all_out();
      return {1'b0, s_ready, mem_we, busy, ack, mem_addr, mem_wdata[14:0]} | {17'd0, mem_wdata[15], 14'd0};
   endfunction

   initial begin
      xrst = 1'b0; req = 1'b0; base_addr = '0; len = '0; s_valid = 1'b0; s_data = '0;
      #2;
      check("rst_outs", all_out(), 32'd0);
      tick(); tick();
      xrst = 1'b1;
      tick();
      check("idle_outs", all_out(), 32'd0);

      // Scenario 1: len=4, back-to-back words
      req = 1'b1; base_addr = 12'h010; len = 12'd4; s_valid = 1'b1; s_data = 32'hBBBBAAAA;
      tick();
      req = 1'b0;
      check("s1_busy", {31'd0, busy}, 32'd1);
      check("s1_recv_rdy", {31'd0, s_ready}, 32'd1);
      check("s1_recv_we", {31'd0, mem_we}, 32'd0);
      tick();
      s_data = 32'hDDDDCCCC;
      check_wr("s1_w0", 12'h010, fh(32'hBBBBAAAA));
      check("s1_lo_rdy", {31'd0, s_ready}, 32'd0);
      tick();
      check_wr("s1_w1", 12'h011, sh(32'hBBBBAAAA));
      check("s1_hi_rdy", {31'd0, s_ready}, 32'd1);
      tick();
      s_data = 32'h99998888;
      check_wr("s1_w2", 12'h012, fh(32'hDDDDCCCC));
      check("s1_lo2_rdy", {31'd0, s_ready}, 32'd0);
      tick();
      check_wr("s1_w3", 12'h013, sh(32'hDDDDCCCC));
      check("s1_last_rdy", {31'd0, s_ready}, 32'd0);
      tick();
      s_valid = 1'b0;
      check("s1_ack", {31'd0, ack}, 32'd1);
      check("s1_done_busy", {31'd0, busy}, 32'd1);
      check("s1_done_we", {31'd0, mem_we}, 32'd0);
      tick();
      check("s1_idle", all_out(), 32'd0);

      // Scenario 2: odd len=3
      req = 1'b1; base_addr = 12'h020; len = 12'd3; s_valid = 1'b1; s_data = 32'h22221111;
      tick();
      req = 1'b0;
      tick();
      s_data = 32'h44443333;
      check_wr("s2_w0", 12'h020, fh(32'h22221111));
      tick();
      check_wr("s2_w1", 12'h021, sh(32'h22221111));
      check("s2_hi_rdy", {31'd0, s_ready}, 32'd1);
      tick();
      s_data = 32'h66665555;
      check_wr("s2_w2", 12'h022, fh(32'h44443333));
      check("s2_lo_rdy", {31'd0, s_ready}, 32'd0);
      tick();
      check("s2_ack", {31'd0, ack}, 32'd1);
      check("s2_done_rdy", {31'd0, s_ready}, 32'd0);
      tick();
      check("s2_idle1", all_out(), 32'd0);
      tick();
      check("s2_idle2", all_out(), 32'd0);
      s_valid = 1'b0;

      // Scenario 3: len=0
      req = 1'b1; base_addr = 12'h030; len = 12'd0;
      tick();
      req = 1'b0;
      check("s3_ack", {31'd0, ack}, 32'd1);
      check("s3_we", {31'd0, mem_we}, 32'd0);
      check("s3_rdy", {31'd0, s_ready}, 32'd0);
      tick();
      check("s3_idle", all_out(), 32'd0);

      // Scenario 4: gapped s_valid with address wrap
      req = 1'b1; base_addr = 12'hFFE; len = 12'd4; s_valid = 1'b0;
      tick();
      req = 1'b0;
      check("s4_recv_rdy", {31'd0, s_ready}, 32'd1);
      tick();
      check("s4_stall_we", {31'd0, mem_we}, 32'd0);
      check("s4_stall_rdy", {31'd0, s_ready}, 32'd1);
      s_valid = 1'b1; s_data = 32'h12345678;
      tick();
      s_valid = 1'b0; s_data = 32'hFFFFFFFF;
      check_wr("s4_w0", 12'hFFE, fh(32'h12345678));
      tick();
      check_wr("s4_w1", 12'hFFF, sh(32'h12345678));
      check("s4_hi_rdy", {31'd0, s_ready}, 32'd1);
      tick();
      check("s4_gap_we", {31'd0, mem_we}, 32'd0);
      check("s4_gap_rdy", {31'd0, s_ready}, 32'd1);
      s_valid = 1'b1; s_data = 32'h9ABCDEF0;
      tick();
      s_valid = 1'b0;
      check_wr("s4_w2", 12'h000, fh(32'h9ABCDEF0));
      tick();
      check_wr("s4_w3", 12'h001, sh(32'h9ABCDEF0));
      tick();
      check("s4_ack", {31'd0, ack}, 32'd1);
      tick();

      // Scenario 5: reset mid-run, then clean restart
      req = 1'b1; base_addr = 12'h100; len = 12'd8; s_valid = 1'b1; s_data = 32'hCAFEF00D;
      tick();
      req = 1'b0;
      tick();
      check_wr("s5_w0", 12'h100, fh(32'hCAFEF00D));
      #2;
      xrst = 1'b0;
      #1;
      check("s5_async_rst", all_out(), 32'd0);
      tick();
      check("s5_rst_hold", all_out(), 32'd0);
      #3;
      xrst = 1'b1;
      s_valid = 1'b0;
      tick();
      check("s5_no_ack", all_out(), 32'd0);
      req = 1'b1; base_addr = 12'h200; len = 12'd2; s_valid = 1'b1; s_data = 32'h55554444;
      tick();
      req = 1'b0;
      tick();
      s_valid = 1'b0;
      check_wr("s5_r0", 12'h200, fh(32'h55554444));
      tick();
      check_wr("s5_r1", 12'h201, sh(32'h55554444));
      check("s5_last_rdy", {31'd0, s_ready}, 32'd0);
      tick();
      check("s5_ack", {31'd0, ack}, 32'd1);
      tick();
      check("s5_idle", all_out(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
